n64_vtiming_ext: RTL and testbench
==================================

N64_VTIMING_EXT -- requirements
Module: n64_vtiming_ext

Interface
REQ-001 SHALL have parameter DATA_PHASES, default 4: demux phases per pixel; power of two, 2..8; DCW = log2(DATA_PHASES).
REQ-002 SHALL have parameter LINE_CNT_W, default 10: line counter width.
REQ-003 SHALL have parameter PAL_THRESH, default 288: lines-per-field threshold for the PAL decision.
REQ-004 SHALL have parameter STABLE_FIELDS, default 2, range 1..15: consecutive identical field decisions required to commit.
REQ-005 SHALL have port VCLK  in  1  video clock; all logic on its rising edge.
REQ-006 SHALL have port nRST  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port nVDSYNC  in  1  low = sync/control phase of the input bus.
REQ-008 SHALL have port Sync_pre  in  4  previous sync nibble; bit3 nVSYNC, bit1 nHSYNC.
REQ-009 SHALL have port Sync_cur  in  4  current sync nibble; same bit order.
REQ-010 SHALL have port data_cnt  out  DCW  demux phase counter.
REQ-011 SHALL have port vmode  out  1  1 = PAL, 0 = NTSC (committed).
REQ-012 SHALL have port n64_480i  out  1  1 = interlaced, 0 = progressive (committed).
REQ-013 SHALL have port line_total  out  LINE_CNT_W  line count of the last completed field.
REQ-014 SHALL have port vinfo_valid  out  1  1 = vmode/n64_480i locked.
REQ-015 SHALL have port mode_change  out  1  one-cycle pulse on a committed change while locked.

Function
REQ-016 SHALL set data_cnt to 1 on nVDSYNC=0, else increment it modulo DATA_PHASES (DATA_PHASES-1 -> 0).
REQ-017 SHALL evaluate sync edges only in cycles with nVDSYNC=0: rising/falling per bit = Sync_pre/Sync_cur 0->1 / 1->0.
REQ-018 SHALL increment the internal line counter on nHSYNC rising, saturating at all-ones (no wrap).
REQ-019 SHALL, on nVSYNC rising, load line_total from the line counter and clear the counter the same cycle.
REQ-020 SHALL give nVSYNC rising priority when it coincides with nHSYNC rising: counter cleared, that HSYNC not counted.
REQ-021 SHALL, on nVSYNC falling, mark the field odd if nHSYNC falls in the same cycle, else even; interlace candidate = parity differs from previous field parity; previous parity then updated.
REQ-022 SHALL, on nVSYNC rising, form candidate {pal_c, int_c}: pal_c = 1 if captured count > PAL_THRESH (unsigned, strict), else 0.
REQ-023 SHALL hold a pending tuple and a 4-bit match counter: candidate equal to pending -> counter +1 (saturating at STABLE_FIELDS); else pending := candidate, counter := 1.
REQ-024 SHALL implement FSM ACQUIRE / LOCKED; reset state ACQUIRE.
REQ-025 SHALL, in ACQUIRE, when the counter reaches STABLE_FIELDS: commit pending to vmode/n64_480i, set vinfo_valid=1, go LOCKED; no mode_change pulse.
REQ-026 SHALL, in LOCKED, when the counter reaches STABLE_FIELDS and pending differs from committed: commit and pulse mode_change for one cycle; vinfo_valid stays 1.
REQ-027 SHALL hold committed outputs unchanged while a mismatch is pending below STABLE_FIELDS.
REQ-028 SHALL, on line counter saturation in any state: go ACQUIRE, vinfo_valid=0, counter := 0, committed outputs held.
REQ-029 SHALL, with STABLE_FIELDS=1, commit on the same nVSYNC rising that produces the candidate.
REQ-030 SHALL register all outputs; commit visible one cycle after the qualifying nVSYNC rising.

Reset
REQ-031 SHALL, while nRST=0, force: data_cnt=0, vmode=0, n64_480i=1, line_total=0, vinfo_valid=0, mode_change=0, line counter 0, previous parity even, pending {0,1}, match counter 0, state ACQUIRE.
REQ-032 SHALL abandon any partial field or pending decision on reset mid-operation; acquisition restarts from scratch.

Verification
REQ-033 SHALL cover: nVDSYNC low one cycle every 4, DATA_PHASES=4 -> data_cnt 1,2,3,0,1...; DATA_PHASES=2 -> 1,0,1,0.
REQ-034 SHALL cover: NTSC progressive, 263 HSYNC/field, all even -> after 2 fields line_total=263, vmode=0, n64_480i=0, vinfo_valid=1, no pulse.
REQ-035 SHALL cover: locked NTSC 240p switched to PAL 480i (313 lines, alternating parity) -> one field hold, then vmode=1, n64_480i=1, single mode_change pulse.
REQ-036 SHALL cover: nVSYNC and nHSYNC rising same cycle -> line_total excludes that line; next field counts from 0.
REQ-037 SHALL cover: VSYNC withheld past 2^LINE_CNT_W-1 lines -> vinfo_valid=0, outputs held; 2 good fields -> relock.
REQ-038 SHALL cover: nRST asserted mid-field while locked -> all outputs at reset values immediately (async); relock needs STABLE_FIELDS full fields.

Source files
------------

// File: rtl/n64_vtiming_ext.sv
// n64_vtiming_ext: N64 video timing extractor; counts lines per field and commits
// a PAL/480i decision once it has been seen on STABLE_FIELDS consecutive fields.
module n64_vtiming_ext #(
    parameter int DATA_PHASES   = 4,
    parameter int LINE_CNT_W    = 10,
    parameter int PAL_THRESH    = 288,
    parameter int STABLE_FIELDS = 2,
    localparam int DCW = $clog2(DATA_PHASES)
) (
    input  logic                  VCLK,
    input  logic                  nRST,
    input  logic                  nVDSYNC,
    input  logic [3:0]            Sync_pre,
    input  logic [3:0]            Sync_cur,
    output logic [DCW-1:0]        data_cnt,
    output logic                  vmode,
    output logic                  n64_480i,
    output logic [LINE_CNT_W-1:0] line_total,
    output logic                  vinfo_valid,
    output logic                  mode_change
);
    localparam logic [3:0] SF = 4'(STABLE_FIELDS);
    localparam logic [LINE_CNT_W-1:0] THR = LINE_CNT_W'(PAL_THRESH);

    typedef enum logic {ACQUIRE, LOCKED} state_t;
    state_t state, state_nxt;

    logic [LINE_CNT_W-1:0] line_cnt;
    logic [1:0] cand, pend;
    logic [3:0] match, match_nxt;
    logic vs_rise, vs_fall, hs_rise, hs_fall, sat, par_prev, int_c, lock, pulse;
    logic unused_bits;

    assign unused_bits = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

    assign vs_rise = !nVDSYNC && !Sync_pre[3] &&  Sync_cur[3];
    assign vs_fall = !nVDSYNC &&  Sync_pre[3] && !Sync_cur[3];
    assign hs_rise = !nVDSYNC && !Sync_pre[1] &&  Sync_cur[1];
    assign hs_fall = !nVDSYNC &&  Sync_pre[1] && !Sync_cur[1];
    // the HSYNC that takes the counter to all-ones is the saturation event
    assign sat = hs_rise && !vs_rise && (&line_cnt[LINE_CNT_W-1:1]) && !line_cnt[0];

    assign cand      = {line_cnt > THR, int_c};
    assign match_nxt = (cand == pend) ? ((match == SF) ? SF : match + 4'd1) : 4'd1;

    always_ff @(posedge VCLK or negedge nRST)
        if (!nRST) state <= ACQUIRE;
        else       state <= state_nxt;

    always_comb
        state_nxt = sat ? ACQUIRE : lock ? LOCKED : state;

    always_comb begin
        lock  = vs_rise && (match_nxt == SF);
        pulse = lock && (state == LOCKED) && (cand != {vmode, n64_480i});
    end

    always_ff @(posedge VCLK or negedge nRST)
        if (!nRST) begin
            data_cnt    <= '0;
            vmode       <= 1'b0;
            n64_480i    <= 1'b1;
            line_total  <= '0;
            vinfo_valid <= 1'b0;
            mode_change <= 1'b0;
            line_cnt    <= '0;
            par_prev    <= 1'b0;
            int_c       <= 1'b0;
            pend        <= 2'b01;
            match       <= 4'd0;
        end else begin
            data_cnt    <= !nVDSYNC ? DCW'(1) : data_cnt + DCW'(1);
            line_cnt    <= vs_rise ? '0 : (hs_rise && line_cnt != '1) ? line_cnt + LINE_CNT_W'(1) : line_cnt;
            mode_change <= pulse;
            vinfo_valid <= sat ? 1'b0 : lock ? 1'b1 : vinfo_valid;
            if (vs_fall) begin
                par_prev <= hs_fall;
                int_c    <= hs_fall != par_prev;
            end
            if (vs_rise) begin
                line_total <= line_cnt;
                pend       <= cand;
                match      <= match_nxt;
            end
            if (sat) match <= 4'd0;
            if (lock) {vmode, n64_480i} <= cand;
        end
endmodule

// File: tb/tb_n64_vtiming_ext.sv
// tb_n64_vtiming_ext: randomized field-level stimulus checked against a field-granular model.
module tb_n64_vtiming_ext;
    localparam int THR = 288, LMAX = 1023, S = 2;

    logic VCLK = 1'b0, nRST = 1'b0, nVDSYNC = 1'b1;
    logic [3:0] Sync_pre = 4'hF, Sync_cur = 4'hF, cur = 4'hF;
    logic [1:0] dc4;
    logic dc2, vmode, n64_480i, vinfo_valid, mode_change;
    logic vmode2, i480_2, valid2, mc2;
    logic [9:0] line_total, lt2;

    int n_chk = 0, n_fail = 0, pulses = 0, e4 = 0, e2 = 0;
    int m_par, m_int, m_pend, m_match, m_locked, m_vmode, m_i480, m_total, m_pulses;

    n64_vtiming_ext dut (.VCLK(VCLK), .nRST(nRST), .nVDSYNC(nVDSYNC), .Sync_pre(Sync_pre),
        .Sync_cur(Sync_cur), .data_cnt(dc4), .vmode(vmode), .n64_480i(n64_480i),
        .line_total(line_total), .vinfo_valid(vinfo_valid), .mode_change(mode_change));

    n64_vtiming_ext #(.DATA_PHASES(2)) dut2 (.VCLK(VCLK), .nRST(nRST), .nVDSYNC(nVDSYNC),
        .Sync_pre(Sync_pre), .Sync_cur(Sync_cur), .data_cnt(dc2), .vmode(vmode2),
        .n64_480i(i480_2), .line_total(lt2), .vinfo_valid(valid2), .mode_change(mc2));

    always #5 VCLK = ~VCLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // phase counters follow the bus: reload to 1 on a sync word, else advance
    always @(posedge VCLK or negedge nRST)
        if (!nRST) begin
            e4 = 0;
            e2 = 0;
        end else begin
            e4 = nVDSYNC ? (e4 + 1) % 4 : 1;
            e2 = nVDSYNC ? (e2 + 1) % 2 : 1;
        end

    always @(negedge VCLK) if (mode_change) pulses++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_par = 0; m_int = 0; m_pend = 1; m_match = 0; m_locked = 0;
        m_vmode = 0; m_i480 = 1; m_total = 0; m_pulses = pulses;
    endtask

    task automatic model_field(input int n, input int odd);
        int cnt, c;
        m_int = (odd != m_par);
        m_par = odd;
        cnt = n;
        if (n >= LMAX) begin
            cnt = LMAX;
            m_locked = 0;
            m_match = 0;
        end
        m_total = cnt;
        c = (cnt > THR) * 2 + m_int;
        if (c == m_pend) m_match = (m_match < S) ? m_match + 1 : S;
        else begin
            m_pend = c;
            m_match = 1;
        end
        if (m_match == S) begin
            if (m_locked && c != m_vmode * 2 + m_i480) m_pulses++;
            m_vmode = c / 2;
            m_i480 = c % 2;
            m_locked = 1;
        end
    endtask

    task automatic check_reset();
        check("rst_data_cnt4", int'(dc4), 0);
        check("rst_data_cnt2", int'(dc2), 0);
        check("rst_vmode", int'(vmode), 0);
        check("rst_480i", int'(n64_480i), 1);
        check("rst_line_total", int'(line_total), 0);
        check("rst_valid", int'(vinfo_valid), 0);
        check("rst_mode_change", int'(mode_change), 0);
    endtask

    task automatic word(input bit vs, input bit hs, input int gap);
        for (int i = 0; i <= gap; i++) begin
            @(negedge VCLK);
            check("data_cnt4", int'(dc4), e4);
            check("data_cnt2", int'(dc2), e2);
            if (i == 0) begin
                nVDSYNC = 1'b0;
                Sync_pre = cur;
                cur = {vs, cur[2], hs, cur[0]};
                Sync_cur = cur;
            end else begin
                nVDSYNC = 1'b1;
                Sync_pre = 4'($urandom);
                Sync_cur = 4'($urandom);
            end
        end
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            word(1'b0, 1'b0, 1);
            word(1'b0, 1'b1, 1);
        end
    endtask

    task automatic field(input int n, input bit odd, input bit coinc);
        word(1'b0, !odd, 3);
        lines(n);
        if (coinc) word(1'b0, 1'b0, 1);
        word(1'b1, 1'b1, 3);
        model_field(n, int'(odd));
        check("line_total", int'(line_total), m_total);
        check("vmode", int'(vmode), m_vmode);
        check("n64_480i", int'(n64_480i), m_i480);
        check("vinfo_valid", int'(vinfo_valid), m_locked);
        check("mode_change_pulses", pulses, m_pulses);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge VCLK);
        check_reset();
        nRST = 1'b1;
        model_reset();
        repeat (4) word(1'b1, 1'b1, 3);
        field(263, 0, 0);
        field(263, 0, 0);
        field(313, 1, 0);
        field(313, 0, 0);
        field(313, 1, 1);
        field(313, 0, 0);
        word(1'b0, 1'b1, 3);
        lines(1025);
        check("sat_valid", int'(vinfo_valid), 0);
        check("sat_vmode_held", int'(vmode), 1);
        word(1'b1, 1'b1, 3);
        model_field(1025, 0);
        check("sat_line_total", int'(line_total), m_total);
        field(263, 0, 0);
        field(263, 0, 0);
        word(1'b0, 1'b1, 3);
        lines(100);
        @(posedge VCLK);
        #3 nRST = 1'b0;
        #1 check_reset();
        repeat (3) @(negedge VCLK);
        nRST = 1'b1;
        cur = 4'hF;
        model_reset();
        field(263, 0, 0);
        field(263, 0, 0);
        for (int k = 0; k < 10; k++) begin
            case ($urandom_range(0, 4))
                0: n = 263;
                1: n = 313;
                2: n = 288;
                3: n = 289;
                default: n = $urandom_range(250, 320);
            endcase
            field(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
